// File: rtl/serial_sub_pkg.sv
// Shared types and reference model for the bit-serial subtractor.
// The reference function is usable by any consumer needing a golden {bout, diff}.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int MAX_WIDTH = 64;

  // Returns {bout, diff} for a - b - bin at the given width (width <= MAX_WIDTH).
  // Bits above width+1 of the result are zero.
  function automatic logic [MAX_WIDTH:0] ref_sub(
    input logic [MAX_WIDTH-1:0] a,
    input logic [MAX_WIDTH-1:0] b,
    input logic                 bin,
    input int                   width
  );
    logic [MAX_WIDTH:0] t;
    logic [MAX_WIDTH:0] mask;
    logic [MAX_WIDTH:0] res;
    mask = ({{MAX_WIDTH{1'b0}}, 1'b1} << width) - 1'b1;
    t    = ({1'b0, a} & mask) - ({1'b0, b} & mask) - {{MAX_WIDTH{1'b0}}, bin};
    res  = t & mask;
    res[width] = t[width];
    return res;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit combinational full-subtractor cell: d = x - y - bi, bo = borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, with start/busy/done handshake.
//   state | meaning
//   IDLE  | waiting for start
//   SHIFT | one bit per edge through the cell
//   DONE  | one-cycle done pulse; start here is accepted like IDLE
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);

  localparam int CW = $clog2(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic             r_bout;
  logic             r_done;
  logic             w_d;
  logic             w_bo;
  logic             w_last;
  logic             w_accept;

  full_subtractor u_cell (
    .x  (r_a[0]),
    .y  (r_b[0]),
    .bi (r_borrow),
    .d  (w_d),
    .bo (w_bo)
  );

  assign w_last   = (r_cnt == CW'(WIDTH - 1));
  assign w_accept = start && (r_state != SHIFT);

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (start) w_next = SHIFT;
      SHIFT:   if (w_last) w_next = DONE;
      DONE:    w_next = start ? SHIFT : IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_res    <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a      <= a;
        r_b      <= b;
        r_res    <= '0;
        r_borrow <= bin;
        r_cnt    <= '0;
      end else if (r_state == SHIFT) begin
        r_a      <= r_a >> 1;
        r_b      <= r_b >> 1;
        r_res    <= {w_d, r_res[WIDTH-1:1]};
        r_borrow <= w_bo;
        if (w_last) begin
          // the final difference bit lands directly in the output register
          r_diff <= {w_d, r_res[WIDTH-1:1]};
          r_bout <= w_bo;
          r_done <= 1'b1;
        end else begin
          r_cnt <= r_cnt + CW'(1);
        end
      end
    end
  end

  assign busy = (r_state == SHIFT);
  assign done = r_done;
  assign diff = r_diff;
  assign bout = r_bout;

endmodule
